fft_ctrl: RTL and testbench
===========================

FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_SIZE, default 5, giving log2 of the FFT point count; N = 2^ADDR_SIZE.
REQ-002 The module SHALL have parameter PIPE_LATENCY, default 3, giving the cycles from a read issue to its matching write in the butterfly pipe.
REQ-003 The module SHALL have port i_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port i_RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port i_start, input, 1 bit: request to start one full transform.
REQ-006 The module SHALL have port o_busy, output, 1 bit: transform in progress.
REQ-007 The module SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-008 The module SHALL have port o_rd_en, output, 1 bit: the current read addresses are valid.
REQ-009 The module SHALL have ports o_rdaddr_A and o_rdaddr_B, output, ADDR_SIZE bits each: butterfly operand addresses.
REQ-010 The module SHALL have port o_rdaddr_twiddle, output, ADDR_SIZE-1 bits: twiddle ROM index.
REQ-011 The module SHALL have port o_wr_en, output, 1 bit: the pipe's write-back outputs are valid this cycle.
REQ-012 The module SHALL have port o_stage, output, ceil(log2(ADDR_SIZE+1)) bits: the current stage index.

Function
REQ-013 The module SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-014 In IDLE, i_start=1 SHALL move the FSM to RUN with stage s=0 and butterfly counter b=0; i_start SHALL be ignored in every other state.
REQ-015 In RUN, each cycle SHALL assert o_rd_en, present addresses for the current (s,b), and then increment b.
REQ-016 The address generation SHALL be as follows:
- span = 2^s
- o_rdaddr_A = ((b >> s) << (s+1)) | (b & (span-1))
- o_rdaddr_B = o_rdaddr_A | span
- o_rdaddr_twiddle = (b & (span-1)) << (ADDR_SIZE-1-s)
- All of these SHALL be truncated to their port widths.
REQ-017 When b = N/2-1 in RUN, the next state SHALL be DRAIN, with b cleared to 0.
REQ-018 DRAIN SHALL last exactly PIPE_LATENCY cycles with o_rd_en=0, so that stage s+1 never reads data still in flight from stage s.
REQ-019 At the end of DRAIN, if s < ADDR_SIZE-1 the FSM SHALL increment s and return to RUN; otherwise it SHALL go to DONE.
REQ-020 DONE SHALL last one cycle with o_done=1 and then go to IDLE.
REQ-021 o_wr_en SHALL equal o_rd_en delayed by exactly PIPE_LATENCY cycles, via a shift register cleared on reset.
REQ-022 o_busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE and DONE.
REQ-023 o_stage SHALL equal s in every state and SHALL be 0 in IDLE.
REQ-024 Total transform length, from the first RUN cycle to the last DRAIN cycle, SHALL be ADDR_SIZE*(N/2+PIPE_LATENCY) cycles; this is 95 for the defaults.
REQ-025 Address outputs SHALL hold 0 whenever o_rd_en=0.
REQ-026 The last o_wr_en of the transform SHALL occur in the final DRAIN cycle, and o_done SHALL follow it in the next cycle.

Reset
REQ-027 While i_RST=1 at a clock edge, the FSM SHALL go to IDLE and s, b and the write-enable shift register SHALL clear.
REQ-028 The reset values of o_busy, o_done, o_rd_en, o_wr_en, o_stage and all address outputs SHALL be 0.
REQ-029 Reset mid-transform SHALL abort immediately, with no further o_wr_en or o_done from the aborted run.
REQ-030 If i_RST and i_start are high together, i_RST SHALL win.

Verification
REQ-031 Scenario 1 (start, defaults): i_start pulse in IDLE -> next cycle o_rd_en=1, s=0, b=0, A=0, B=1, tw=0; following cycle A=2, B=3.
REQ-032 Scenario 2 (stage 2): stage 2, b=5 -> A=9, B=13, tw=4; stage 4, b=7 -> A=7, B=23, tw=7.
REQ-033 Scenario 3 (full run): a full run SHALL produce these counts:
- 80 o_rd_en cycles and 80 o_wr_en cycles.
- o_busy high for 95 cycles.
- A single o_done pulse, then IDLE.
- Every (A,B) pair unique within each stage.
REQ-034 Scenario 4 (drain gap): after the last read of stage 0 -> exactly 3 cycles with o_rd_en=0, and the last stage-0 o_wr_en occurs before the first stage-1 o_rd_en.
REQ-035 Scenario 5 (start while busy): i_start held high through the whole run -> no restart until IDLE; a new run begins on the cycle after IDLE is re-entered.
REQ-036 Scenario 6 (reset mid-run): i_RST asserted for one cycle at stage 2 -> all outputs 0 on the next cycle, no o_done, and a fresh i_start restarts at s=0.

Source files
------------

// File: rtl/fft_ctrl_if.sv
// Start/status handshake and butterfly memory-address bus between the FFT sequencer
// and the datapath it drives.
interface fft_ctrl_if #(
    parameter int unsigned ADDR_SIZE = 5
) ();
    localparam int unsigned STAGE_W = $clog2(ADDR_SIZE + 1);

    logic                 i_start;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_rd_en;
    logic [ADDR_SIZE-1:0] o_rdaddr_A;
    logic [ADDR_SIZE-1:0] o_rdaddr_B;
    logic [ADDR_SIZE-2:0] o_rdaddr_twiddle;
    logic                 o_wr_en;
    logic [STAGE_W-1:0]   o_stage;

    modport master (
        input  i_start,
        output o_busy, o_done, o_rd_en, o_rdaddr_A, o_rdaddr_B, o_rdaddr_twiddle,
        output o_wr_en, o_stage
    );

    modport slave (
        output i_start,
        input  o_busy, o_done, o_rd_en, o_rdaddr_A, o_rdaddr_B, o_rdaddr_twiddle,
        input  o_wr_en, o_stage
    );
endinterface

// File: rtl/fft_ctrl.sv
// Radix-2 in-place FFT sequencer: walks stages and butterflies, issues operand/twiddle
// addresses, and drains the butterfly pipe between stages. Expects ADDR_SIZE >= 2.
module fft_ctrl #(
    parameter int unsigned ADDR_SIZE    = 5,
    parameter int unsigned PIPE_LATENCY = 3
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    fft_ctrl_if.master io_fft
);
    localparam int unsigned SW = $clog2(ADDR_SIZE + 1);
    localparam int unsigned BW = ADDR_SIZE - 1;
    localparam int unsigned DW = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                  r_state;
    logic [SW-1:0]           r_s;
    logic [BW-1:0]           r_b;
    logic [DW-1:0]           r_drain;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_rd_en;
    logic [ADDR_SIZE-1:0]    r_addr_a;
    logic [ADDR_SIZE-1:0]    r_addr_b;
    logic [BW-1:0]           r_tw;
    logic [PIPE_LATENCY-1:0] r_wr_sr;

    logic [SW-1:0]           w_gen_s;
    logic [BW-1:0]           w_gen_b;
    logic [BW-1:0]           w_mask;
    logic [BW-1:0]           w_low_b;
    logic [ADDR_SIZE-1:0]    w_bx;
    logic [ADDR_SIZE-1:0]    w_addr_a;
    logic [ADDR_SIZE-1:0]    w_addr_b;
    logic [BW-1:0]           w_tw;

    // Addresses are registered, so generate them for the (s,b) that the next cycle presents.
    always_comb begin
        w_gen_s = r_s;
        w_gen_b = r_b + BW'(1);
        if (r_state == StIdle) begin
            w_gen_s = '0;
            w_gen_b = '0;
        end else if (r_state == StDrain) begin
            w_gen_s = r_s + SW'(1);
            w_gen_b = '0;
        end
        w_mask   = (BW'(1) << w_gen_s) - BW'(1);
        w_low_b  = w_gen_b & w_mask;
        w_bx     = {1'b0, w_gen_b};
        w_addr_a = ((w_bx >> w_gen_s) << (w_gen_s + SW'(1))) | {1'b0, w_low_b};
        w_addr_b = w_addr_a | (ADDR_SIZE'(1) << w_gen_s);
        w_tw     = w_low_b << (SW'(ADDR_SIZE - 1) - w_gen_s);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state  <= StIdle;
            r_s      <= '0;
            r_b      <= '0;
            r_drain  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd_en  <= 1'b0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_tw     <= '0;
            r_wr_sr  <= '0;
        end else begin
            r_wr_sr <= (r_wr_sr << 1) | PIPE_LATENCY'(r_rd_en);
            r_done  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_fft.i_start) begin
                        r_state  <= StRun;
                        r_s      <= '0;
                        r_b      <= '0;
                        r_busy   <= 1'b1;
                        r_rd_en  <= 1'b1;
                        r_addr_a <= w_addr_a;
                        r_addr_b <= w_addr_b;
                        r_tw     <= w_tw;
                    end
                end
                StRun: begin
                    if (r_b == {BW{1'b1}}) begin
                        r_state  <= StDrain;
                        r_b      <= '0;
                        r_drain  <= '0;
                        r_rd_en  <= 1'b0;
                        r_addr_a <= '0;
                        r_addr_b <= '0;
                        r_tw     <= '0;
                    end else begin
                        r_b      <= r_b + BW'(1);
                        r_addr_a <= w_addr_a;
                        r_addr_b <= w_addr_b;
                        r_tw     <= w_tw;
                    end
                end
                StDrain: begin
                    if (r_drain == DW'(PIPE_LATENCY - 1)) begin
                        if (r_s < SW'(ADDR_SIZE - 1)) begin
                            r_state  <= StRun;
                            r_s      <= r_s + SW'(1);
                            r_rd_en  <= 1'b1;
                            r_addr_a <= w_addr_a;
                            r_addr_b <= w_addr_b;
                            r_tw     <= w_tw;
                        end else begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_s     <= '0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_fft.o_busy           = r_busy;
    assign io_fft.o_done           = r_done;
    assign io_fft.o_rd_en          = r_rd_en;
    assign io_fft.o_rdaddr_A       = r_addr_a;
    assign io_fft.o_rdaddr_B       = r_addr_b;
    assign io_fft.o_rdaddr_twiddle = r_tw;
    assign io_fft.o_wr_en          = r_wr_sr[PIPE_LATENCY-1];
    assign io_fft.o_stage          = r_s;
endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl: directed scenarios plus random start/reset traffic, every cycle
// compared against a per-run expected trace built from the addressing rules.
module tb_fft_ctrl;
    localparam int unsigned AS   = 5;
    localparam int unsigned PL   = 3;
    localparam int unsigned N    = 1 << AS;
    localparam int unsigned HALF = N / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_ctrl_if #(.ADDR_SIZE(AS)) u_if ();

    fft_ctrl #(
        .ADDR_SIZE   (AS),
        .PIPE_LATENCY(PL)
    ) u_dut (
        .i_CLK (clk),
        .i_RST (rst),
        .io_fft(u_if)
    );

    int          n_checks;
    int          n_errors;
    logic [31:0] q[$];
    bit          m_idle;

    int          cyc, n_rd, n_wr, n_busy, n_done, done_cyc, last_wr_cyc, n_dup, wr_half_cyc;
    int          rd_idx[AS];
    int          rd_first[AS];
    int          rd_last[AS];
    bit          seen[AS][N*N];
    bit          prev_busy;
    int          run_starts[$];
    int          done_list[$];
    logic [31:0] s2_obs, s4_obs;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Word layout: busy[20] done[19] rd[18] wr[17] stage[16:14] A[13:9] B[8:4] tw[3:0]
    function automatic logic [31:0] mkw(input bit busy, input bit done, input bit rd,
                                        input bit wr, input int stg, input int a,
                                        input int b, input int tw);
        return {11'b0, busy, done, rd, wr, 3'(stg), 5'(a), 5'(b), 4'(tw)};
    endfunction

    function automatic logic [31:0] obs_word();
        return {11'b0, u_if.o_busy, u_if.o_done, u_if.o_rd_en, u_if.o_wr_en, u_if.o_stage,
                u_if.o_rdaddr_A, u_if.o_rdaddr_B, u_if.o_rdaddr_twiddle};
    endfunction

    function automatic logic [31:0] abt(input int a, input int b, input int tw);
        return (a << 16) | (b << 8) | tw;
    endfunction

    function automatic logic [31:0] dut_abt();
        return abt(int'(u_if.o_rdaddr_A), int'(u_if.o_rdaddr_B), int'(u_if.o_rdaddr_twiddle));
    endfunction

    task automatic push_run();
        logic [31:0] tr[$];
        bit          rdv[$];
        for (int s = 0; s < AS; s++) begin
            int span = 1 << s;
            for (int b = 0; b < HALF; b++) begin
                int a = (b / span) * 2 * span + (b % span);
                tr.push_back(mkw(1, 0, 1, 0, s, a, a + span, (b % span) * (HALF / span)));
                rdv.push_back(1'b1);
            end
            for (int d = 0; d < PL; d++) begin
                tr.push_back(mkw(1, 0, 0, 0, s, 0, 0, 0));
                rdv.push_back(1'b0);
            end
        end
        tr.push_back(mkw(0, 1, 0, 0, AS - 1, 0, 0, 0));
        rdv.push_back(1'b0);
        for (int i = PL; i < tr.size(); i++) if (rdv[i-PL]) tr[i][17] = 1'b1;
        foreach (tr[i]) q.push_back(tr[i]);
    endtask

    task automatic clr_stats();
        n_rd = 0; n_wr = 0; n_busy = 0; n_done = 0; done_cyc = -1; last_wr_cyc = -1;
        n_dup = 0; wr_half_cyc = -1; s2_obs = '0; s4_obs = '0;
        run_starts.delete();
        done_list.delete();
        for (int s = 0; s < AS; s++) begin
            rd_idx[s] = 0; rd_first[s] = -1; rd_last[s] = -1;
            for (int k = 0; k < N * N; k++) seen[s][k] = 1'b0;
        end
    endtask

    task automatic step(input bit start, input bit do_rst);
        logic [31:0] exp;
        int          s;
        u_if.i_start = start;
        rst          = do_rst;
        @(posedge clk);
        #1;
        cyc++;
        if (do_rst) q.delete();
        else if (start && m_idle) push_run();
        if (q.size() > 0) begin
            exp    = q.pop_front();
            m_idle = 1'b0;
        end else begin
            exp    = '0;
            m_idle = 1'b1;
        end
        chk_eq("cycle", obs_word(), exp);

        s = int'(u_if.o_stage);
        if (u_if.o_rd_en && s < AS) begin
            n_rd++;
            if (rd_first[s] < 0) rd_first[s] = cyc;
            rd_last[s] = cyc;
            if (seen[s][u_if.o_rdaddr_A * N + u_if.o_rdaddr_B]) n_dup++;
            seen[s][u_if.o_rdaddr_A * N + u_if.o_rdaddr_B] = 1'b1;
            if (s == 2 && rd_idx[s] == 5) s2_obs = dut_abt();
            if (s == 4 && rd_idx[s] == 7) s4_obs = dut_abt();
            if (s == 0 && !prev_busy) run_starts.push_back(cyc);
            rd_idx[s]++;
        end
        if (u_if.o_wr_en) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (n_wr == HALF) wr_half_cyc = cyc;
        end
        if (u_if.o_busy) n_busy++;
        if (u_if.o_done) begin
            n_done++;
            done_cyc = cyc;
            done_list.push_back(cyc);
        end
        prev_busy = u_if.o_busy;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_checks = 0; n_errors = 0; cyc = 0; m_idle = 1'b1; prev_busy = 1'b0;
        rst = 1'b1;
        u_if.i_start = 1'b0;
        clr_stats();

        repeat (3) step(0, 1);
        chk_eq("reset_outputs", obs_word(), 32'h0);
        step(1, 1);
        chk_eq("reset_beats_start", obs_word(), 32'h0);
        step(0, 0);

        // Single full transform with defaults
        clr_stats();
        step(1, 0);
        chk_eq("s1_rd_en", 32'(u_if.o_rd_en), 32'd1);
        chk_eq("s1_stage", 32'(u_if.o_stage), 32'd0);
        chk_eq("s1_addr_b0", dut_abt(), abt(0, 1, 0));
        step(0, 0);
        chk_eq("s1_addr_b1", dut_abt(), abt(2, 3, 0));
        repeat (110) step(0, 0);
        chk_eq("s2_st2_b5", s2_obs, abt(9, 13, 4));
        chk_eq("s2_st4_b7", s4_obs, abt(7, 23, 7));
        chk_eq("s3_rd_count", n_rd, 80);
        chk_eq("s3_wr_count", n_wr, 80);
        chk_eq("s3_busy_count", n_busy, 95);
        chk_eq("s3_done_count", n_done, 1);
        chk_eq("s3_pair_dups", n_dup, 0);
        chk_eq("s3_done_after_last_wr", done_cyc - last_wr_cyc, 1);
        chk_eq("s3_idle_after", obs_word(), 32'h0);
        chk_eq("s4_drain_gap", rd_first[1] - rd_last[0] - 1, PL);
        chk_eq("s4_wr_before_next_rd", 32'(wr_half_cyc < rd_first[1]), 32'd1);

        // Start held high across runs
        clr_stats();
        repeat (250) step(1, 0);
        chk_eq("s5_done_count", n_done, 2);
        chk_eq("s5_run_starts", run_starts.size(), 3);
        if (run_starts.size() >= 2 && done_list.size() >= 1)
            chk_eq("s5_restart_gap", run_starts[1] - done_list[0], 2);
        else
            chk_eq("s5_restart_seen", run_starts.size() * 10 + done_list.size(), 21);
        repeat (120) step(0, 0);

        // Reset in the middle of stage 2
        clr_stats();
        step(1, 0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (u_if.o_stage == 2) found = 1'b1;
            else step(0, 0);
        end
        chk_eq("s6_reach_stage2", 32'(found), 32'd1);
        step(0, 1);
        chk_eq("s6_zero_after_rst", obs_word(), 32'h0);
        clr_stats();
        repeat (150) step(0, 0);
        chk_eq("s6_no_done", n_done, 0);
        chk_eq("s6_no_wr", n_wr, 0);
        step(1, 0);
        chk_eq("s6_restart_rd", 32'(u_if.o_rd_en), 32'd1);
        chk_eq("s6_restart_stage", 32'(u_if.o_stage), 32'd0);
        chk_eq("s6_restart_addr", dut_abt(), abt(0, 1, 0));
        repeat (100) step(0, 0);

        // Random start/reset traffic against the trace model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 399) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
